atomrvcore_dccm_arbiter: RTL and testbench

Two-requester arbiter that shares the single DCCM port between the core load/store path (port 0) and the debug/DMA path (port 1). It selects one request per cycle and drives the DCCM address, read enable, write enable and write data. Read data is routed back to the owning requester one cycle later. It sits between the LSU/debug masters and the DCCM, which registers read data on the clock edge that samples its read enable.

---
 rtl/atomrvcore_dccm_arbiter.sv | 148 ++++++++++++++
 tb/tb_atomrvcore_dccm_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_dccm_arbiter.sv
// Two-requester DCCM port arbiter: core LSU (port 0) and debug/DMA (port 1), with port-1 bus lock.
// Optional port-1 anti-starvation priority is enabled by defining ATOMRV_DCCM_ARB_STARVE_EN.
module atomrvcore_dccm_arbiter #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p0_req_i,
    input  logic                 p0_we_i,
    input  logic [DATAWIDTH-1:0] p0_addr_i,
    input  logic [DATAWIDTH-1:0] p0_wdata_i,
    input  logic                 p1_req_i,
    input  logic                 p1_we_i,
    input  logic [DATAWIDTH-1:0] p1_addr_i,
    input  logic [DATAWIDTH-1:0] p1_wdata_i,
    input  logic                 p1_lock_i,
    output logic                 p0_gnt_o,
    output logic                 p1_gnt_o,
    output logic                 p0_rvalid_o,
    output logic                 p1_rvalid_o,
    output logic [DATAWIDTH-1:0] p0_rdata_o,
    output logic [DATAWIDTH-1:0] p1_rdata_o,
    output logic [DATAWIDTH-1:0] dccm_addr_o,
    output logic                 dccm_dr_en_o,
    output logic                 dccm_dwr_en_o,
    output logic [DATAWIDTH-1:0] dccm_wdata_o,
    input  logic [DATAWIDTH-1:0] dccm_rdata_i
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   rd_pend_valid_q, rd_pend_valid_d;
    logic   rd_pend_owner_q, rd_pend_owner_d;
    logic   p1_prio;
    logic   p0_gnt, p1_gnt;

`ifdef ATOMRV_DCCM_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Counts only denied port-1 cycles; any grant or idle cycle restarts the window.
    always_comb begin
        starve_cnt_d = '0;
        if (p1_req_i && !p1_gnt) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
        end
    end

    assign p1_prio = (starve_cnt_q == CNT_MAX);
`else
    assign p1_prio = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ARB;
            rd_pend_valid_q <= 1'b0;
            rd_pend_owner_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_pend_valid_q <= rd_pend_valid_d;
            rd_pend_owner_q <= rd_pend_owner_d;
        end
    end

    // Arbitration: grants are suppressed while reset is held.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst_i) begin
            if (state_q == LOCK1) begin
                p1_gnt = p1_req_i;
            end else if (p1_prio && p1_req_i) begin
                p1_gnt = 1'b1;
            end else if (p0_req_i) begin
                p0_gnt = 1'b1;
            end else begin
                p1_gnt = p1_req_i;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d         = state_q;
        rd_pend_valid_d = (p0_gnt && !p0_we_i) || (p1_gnt && !p1_we_i);
        rd_pend_owner_d = p1_gnt;
        unique case (state_q)
            ARB: begin
                if (p1_gnt && p1_lock_i) begin
                    state_d = LOCK1;
                end
            end
            LOCK1: begin
                if (!p1_req_i || (p1_gnt && !p1_lock_i)) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Output logic
    always_comb begin
        p0_gnt_o      = p0_gnt;
        p1_gnt_o      = p1_gnt;
        dccm_addr_o   = '0;
        dccm_wdata_o  = '0;
        dccm_dr_en_o  = 1'b0;
        dccm_dwr_en_o = 1'b0;
        if (p0_gnt) begin
            dccm_addr_o   = p0_addr_i;
            dccm_wdata_o  = p0_wdata_i;
            dccm_dr_en_o  = !p0_we_i;
            dccm_dwr_en_o = p0_we_i;
        end else if (p1_gnt) begin
            dccm_addr_o   = p1_addr_i;
            dccm_wdata_o  = p1_wdata_i;
            dccm_dr_en_o  = !p1_we_i;
            dccm_dwr_en_o = p1_we_i;
        end
        p0_rvalid_o = rd_pend_valid_q && !rd_pend_owner_q;
        p1_rvalid_o = rd_pend_valid_q && rd_pend_owner_q;
        p0_rdata_o  = p0_rvalid_o ? dccm_rdata_i : '0;
        p1_rdata_o  = p1_rvalid_o ? dccm_rdata_i : '0;
    end

endmodule

// File: tb/tb_atomrvcore_dccm_arbiter.sv
// Directed bench for atomrvcore_dccm_arbiter with a behavioural DCCM that registers read data.
// Contention expectations follow ATOMRV_DCCM_ARB_STARVE_EN.
module tb_atomrvcore_dccm_arbiter;
    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p0_req_i, p0_we_i, p1_req_i, p1_we_i, p1_lock_i;
    logic [W-1:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic         p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [W-1:0] p0_rdata_o, p1_rdata_o;
    logic [W-1:0] dccm_addr_o, dccm_wdata_o;
    logic         dccm_dr_en_o, dccm_dwr_en_o;
    logic [W-1:0] dccm_rdata_i;

    logic [W-1:0] mem [256];
    int           n_total = 0;
    int           n_bad   = 0;

    atomrvcore_dccm_arbiter #(
        .DATAWIDTH   (W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p0_req_i     (p0_req_i),
        .p0_we_i      (p0_we_i),
        .p0_addr_i    (p0_addr_i),
        .p0_wdata_i   (p0_wdata_i),
        .p1_req_i     (p1_req_i),
        .p1_we_i      (p1_we_i),
        .p1_addr_i    (p1_addr_i),
        .p1_wdata_i   (p1_wdata_i),
        .p1_lock_i    (p1_lock_i),
        .p0_gnt_o     (p0_gnt_o),
        .p1_gnt_o     (p1_gnt_o),
        .p0_rvalid_o  (p0_rvalid_o),
        .p1_rvalid_o  (p1_rvalid_o),
        .p0_rdata_o   (p0_rdata_o),
        .p1_rdata_o   (p1_rdata_o),
        .dccm_addr_o  (dccm_addr_o),
        .dccm_dr_en_o (dccm_dr_en_o),
        .dccm_dwr_en_o(dccm_dwr_en_o),
        .dccm_wdata_o (dccm_wdata_o),
        .dccm_rdata_i (dccm_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        dccm_rdata_i = '0;
    end

    always @(posedge clk_i) begin
        if (dccm_dwr_en_o) mem[dccm_addr_o[9:2]] <= dccm_wdata_o;
        if (dccm_dr_en_o) dccm_rdata_i <= mem[dccm_addr_o[9:2]];
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_p0(input logic req, input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata);
        p0_req_i = req; p0_we_i = we; p0_addr_i = addr; p0_wdata_i = wdata;
    endtask

    task automatic drive_p1(input logic req, input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, input logic lock);
        p1_req_i = req; p1_we_i = we; p1_addr_i = addr; p1_wdata_i = wdata; p1_lock_i = lock;
    endtask

    function automatic logic [W-1:0] ctl_vec();
        return W'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, dccm_dr_en_o, dccm_dwr_en_o});
    endfunction

    initial begin
        // Reset with a pending p0 request: nothing may be granted.
        rst_i = 1'b1;
        drive_p0(1'b1, 1'b0, 32'h40, '0);
        drive_p1(1'b1, 1'b0, 32'h100, '0, 1'b0);
        repeat (3) cyc();
        check_eq("rst_ctl", ctl_vec(), '0);
        drive_p0(1'b0, 1'b0, '0, '0);
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0);
        rst_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc(); settle();
            check_eq("idle_ctl", ctl_vec(), '0);
        end

        // Port-0 write then read of the same word.
        cyc();
        drive_p0(1'b1, 1'b1, 32'h40, 32'hDEADBEEF); settle();
        check_eq("p0w_ctl", ctl_vec(), W'(6'b100001));
        check_eq("p0w_addr", dccm_addr_o, 32'h40);
        check_eq("p0w_wdata", dccm_wdata_o, 32'hDEADBEEF);
        cyc();
        drive_p0(1'b1, 1'b0, 32'h40, '0); settle();
        check_eq("p0r_ctl", ctl_vec(), W'(6'b100010));
        cyc();
        drive_p0(1'b0, 1'b0, '0, '0); settle();
        check_eq("p0r_rvalid", ctl_vec(), W'(6'b001000));
        check_eq("p0r_rdata", p0_rdata_o, 32'hDEADBEEF);

        // Contention: both ports read continuously.
        cyc();
        drive_p0(1'b1, 1'b0, 32'h40, '0);
        drive_p1(1'b1, 1'b0, 32'h100, '0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            settle();
`ifdef ATOMRV_DCCM_ARB_STARVE_EN
            check_eq($sformatf("cont_p1gnt_%0d", k), W'(p1_gnt_o), W'(k == 5));
            check_eq($sformatf("cont_p0gnt_%0d", k), W'(p0_gnt_o), W'(k != 5));
            if (k == 6) check_eq("cont_p1rv", W'(p1_rvalid_o), W'(1));
`else
            check_eq($sformatf("cont_p1gnt_%0d", k), W'(p1_gnt_o), '0);
            check_eq($sformatf("cont_p0gnt_%0d", k), W'(p0_gnt_o), W'(1));
`endif
            if (k == 2) begin
                check_eq("cont_p0rv", W'(p0_rvalid_o), W'(1));
                check_eq("cont_p0rd", p0_rdata_o, 32'hDEADBEEF);
            end
            cyc();
        end
        drive_p0(1'b0, 1'b0, '0, '0);
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0);
        cyc();

        // Lock burst: p1 claims the bus, p0 joins and is held off until the unlocked beat.
        drive_p1(1'b1, 1'b1, 32'h100, 32'h1, 1'b1); settle();
        check_eq("lock_b1_ctl", ctl_vec(), W'(6'b010001));
        check_eq("lock_b1_addr", dccm_addr_o, 32'h100);
        cyc();
        drive_p0(1'b1, 1'b0, 32'h40, '0);
        drive_p1(1'b1, 1'b1, 32'h104, 32'h2, 1'b1); settle();
        check_eq("lock_b2_ctl", ctl_vec(), W'(6'b010001));
        check_eq("lock_b2_wdata", dccm_wdata_o, 32'h2);
        cyc();
        drive_p1(1'b1, 1'b1, 32'h108, 32'h3, 1'b0); settle();
        check_eq("lock_b3_ctl", ctl_vec(), W'(6'b010001));
        check_eq("lock_b3_addr", dccm_addr_o, 32'h108);
        cyc();
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0); settle();
        check_eq("lock_p0_ctl", ctl_vec(), W'(6'b100010));
        cyc();
        drive_p0(1'b0, 1'b0, '0, '0);
        drive_p1(1'b1, 1'b0, 32'h104, '0, 1'b0); settle();
        check_eq("lock_rd_gnt", W'(p1_gnt_o), W'(1));
        cyc();
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0); settle();
        check_eq("lock_rd_rv", W'(p1_rvalid_o), W'(1));
        check_eq("lock_rd_data", p1_rdata_o, 32'h2);

        // Lock released by dropping the request.
        cyc();
        drive_p1(1'b1, 1'b0, 32'h100, '0, 1'b1); settle();
        check_eq("drop_gnt", W'(p1_gnt_o), W'(1));
        cyc();
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0);
        drive_p0(1'b1, 1'b0, 32'h108, '0); settle();
        check_eq("drop_ctl", ctl_vec(), W'(6'b000100));
        check_eq("drop_rdata", p1_rdata_o, 32'h1);
        check_eq("drop_addr", dccm_addr_o, '0);
        cyc(); settle();
        check_eq("drop_p0gnt", W'(p0_gnt_o), W'(1));
        cyc(); settle();
        check_eq("drop_p0rv", W'(p0_rvalid_o), W'(1));
        check_eq("drop_p0rd", p0_rdata_o, 32'h3);

        // Reset while a read is pending.
        drive_p0(1'b1, 1'b0, 32'h40, '0);
        cyc();
        drive_p0(1'b0, 1'b0, '0, '0); settle();
        check_eq("rstrd_pre", W'(p0_rvalid_o), W'(1));
        rst_i = 1'b1;
        #1;
        check_eq("rstrd_async", ctl_vec(), '0);
        cyc();
        rst_i = 1'b0;
        drive_p0(1'b1, 1'b0, 32'h40, '0);
        drive_p1(1'b1, 1'b0, 32'h100, '0, 1'b0); settle();
        check_eq("rstrd_arb", ctl_vec(), W'(6'b100010));

        // Reset taken inside a lock must return to ARB.
        cyc();
        drive_p0(1'b0, 1'b0, '0, '0);
        drive_p1(1'b1, 1'b0, 32'h100, '0, 1'b1);
        cyc();
        drive_p0(1'b1, 1'b0, 32'h40, '0); settle();
        check_eq("lkrst_held", W'({p0_gnt_o, p1_gnt_o}), W'(2'b01));
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0; settle();
        check_eq("lkrst_arb", W'({p0_gnt_o, p1_gnt_o}), W'(2'b10));

        drive_p0(1'b0, 1'b0, '0, '0);
        drive_p1(1'b0, 1'b0, '0, '0, 1'b0);
        cyc();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
